// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle control unit:
// state codes, opcode/funct constants, class and select encodings.
package mc_defs;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXE    = 4'd3,
        S_MEMADR = 4'd4,
        S_MEMRD  = 4'd5,
        S_MEMWB  = 4'd6,
        S_MEMWR  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW,
        C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } cls_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_31  = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing an instruction class.
// Ports: i op, funct (IR fields); o cls (class), illegal (undefined op).
module mc_decode
    import mc_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        case (op)
            OP_R: begin
                if (funct == FN_ADDU)
                    cls = C_ADDU;
                else if (funct == FN_SUBU)
                    cls = C_SUBU;
                else
                    cls = C_ILL;
            end
            OP_ORI: cls = C_ORI;
            OP_LUI: cls = C_LUI;
            OP_LW:  cls = C_LW;
            OP_SW:  cls = C_SW;
            OP_BEQ: cls = C_BEQ;
            OP_J:   cls = C_J;
            OP_JAL: cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end

    assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback.
// Ports: i clk, rst_n, op, funct, zero; o write enables, selects,
// illegal pulse and debug state code.
module mc_ctrl
    import mc_defs::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       GPRWr,
    output logic       DMWr,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       BSel,
    output logic [1:0] ExtOp,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       illegal,
    output logic [3:0] state
);

    state_t r_state;
    cls_t   w_cls;
    logic   w_ill;

    mc_decode u_dec (
        .op      (op),
        .funct   (funct),
        .cls     (w_cls),
        .illegal (w_ill)
    );

    assign state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_cls)
                        C_ADDU, C_SUBU,
                        C_ORI, C_LUI:  r_state <= S_EXE;
                        C_LW, C_SW:    r_state <= S_MEMADR;
                        C_BEQ:         r_state <= S_BRANCH;
                        C_J, C_JAL:    r_state <= S_JUMP;
                        default:
                            r_state <= ILLEGAL_TRAP ? S_TRAP
                                                    : S_FETCH;
                    endcase
                end
                S_EXE:    r_state <= S_ALUWB;
                S_MEMADR:
                    r_state <= (w_cls == C_LW) ? S_MEMRD
                                               : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs depend on state and the stable IR fields only;
    // zero reaches an enable solely through PCWr in S_BRANCH.
    always_comb begin
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        GPRWr   = 1'b0;
        DMWr    = 1'b0;
        RegDst  = RD_RT;
        WDSel   = WD_ALU;
        BSel    = 1'b0;
        ExtOp   = EXT_ZERO;
        ALUOp   = ALU_ADD;
        NPCOp   = NPC_PC4;
        illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWr = 1'b1;
                PCWr = 1'b1;
            end
            S_DECODE: illegal = w_ill;
            S_EXE, S_ALUWB: begin
                case (w_cls)
                    C_SUBU: ALUOp = ALU_SUB;
                    C_ORI: begin
                        BSel  = 1'b1;
                        ALUOp = ALU_OR;
                    end
                    C_LUI: begin
                        BSel  = 1'b1;
                        ExtOp = EXT_LUI;
                        ALUOp = ALU_PASS;
                    end
                    default: ALUOp = ALU_ADD;
                endcase
                if (r_state == S_ALUWB) begin
                    GPRWr  = 1'b1;
                    RegDst = (w_cls == C_ADDU ||
                              w_cls == C_SUBU) ? RD_RD
                                               : RD_RT;
                end
            end
            S_MEMADR: begin
                BSel  = 1'b1;
                ExtOp = EXT_SIGN;
            end
            S_MEMWB: begin
                GPRWr = 1'b1;
                WDSel = WD_DM;
            end
            S_MEMWR: DMWr = 1'b1;
            S_BRANCH: begin
                ALUOp = ALU_SUB;
                NPCOp = NPC_BR;
                PCWr  = zero;
            end
            S_JUMP: begin
                PCWr  = 1'b1;
                NPCOp = NPC_J;
                if (w_cls == C_JAL) begin
                    GPRWr  = 1'b1;
                    RegDst = RD_31;
                    WDSel  = WD_PC;
                end
            end
            default: ;
        endcase
        // Reset overrides everything so no stale write escapes.
        if (!rst_n) begin
            PCWr    = 1'b0;
            IRWr    = 1'b0;
            GPRWr   = 1'b0;
            DMWr    = 1'b0;
            RegDst  = RD_RT;
            WDSel   = WD_ALU;
            BSel    = 1'b0;
            ExtOp   = EXT_ZERO;
            ALUOp   = ALU_ADD;
            NPCOp   = NPC_PC4;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Vector/scoreboard bench for mc_ctrl plus trap-mode corner case.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero;

    logic       PCWr, IRWr, GPRWr, DMWr, BSel, illegal;
    logic [1:0] RegDst, WDSel, ExtOp, NPCOp;
    logic [2:0] ALUOp;
    logic [3:0] state;

    logic       t_PCWr, t_IRWr, t_GPRWr, t_DMWr, t_BSel, t_ill;
    logic [1:0] t_RegDst, t_WDSel, t_ExtOp, t_NPCOp;
    logic [2:0] t_ALUOp;
    logic [3:0] t_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.ILLEGAL_TRAP(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .zero(zero), .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr),
        .DMWr(DMWr), .RegDst(RegDst), .WDSel(WDSel),
        .BSel(BSel), .ExtOp(ExtOp), .ALUOp(ALUOp),
        .NPCOp(NPCOp), .illegal(illegal), .state(state)
    );

    mc_ctrl #(.ILLEGAL_TRAP(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .zero(zero), .PCWr(t_PCWr), .IRWr(t_IRWr),
        .GPRWr(t_GPRWr), .DMWr(t_DMWr), .RegDst(t_RegDst),
        .WDSel(t_WDSel), .BSel(t_BSel), .ExtOp(t_ExtOp),
        .ALUOp(t_ALUOp), .NPCOp(t_NPCOp), .illegal(t_ill),
        .state(t_state)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        r;
        logic        cs;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    // out = {PCWr,IRWr,GPRWr,DMWr,RegDst,WDSel,BSel,ExtOp,ALUOp,NPCOp,ill}
    function automatic vec_t V(
        input logic [5:0] o, input logic [5:0] f,
        input logic z, input logic r, input logic cs,
        input logic [3:0] st, input logic [3:0] en,
        input logic [1:0] rd, input logic [1:0] wd,
        input logic bs, input logic [1:0] ex,
        input logic [2:0] alu, input logic [1:0] npc,
        input logic il);
        vec_t v;
        v.op = o; v.fn = f; v.z = z; v.r = r;
        v.cs = cs; v.st = st;
        v.out = {en, rd, wd, bs, ex, alu, npc, il};
        return v;
    endfunction

    function automatic logic [16:0] got_u0();
        return {PCWr, IRWr, GPRWr, DMWr, RegDst, WDSel, BSel,
                ExtOp, ALUOp, NPCOp, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        op = v.op; funct = v.fn; zero = v.z; rst_n = v.r;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk($sformatf("vec%0d_out", idx),
            {15'd0, got_u0()}, {15'd0, e.out});
        if (e.cs)
            chk($sformatf("vec%0d_state", idx),
                {28'd0, state}, {28'd0, e.st});
        if (GPRWr && DMWr)
            chk($sformatf("vec%0d_onehot", idx), 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] LUI = 6'b001111;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] BAD = 6'b111111;
    localparam logic [5:0] AD  = 6'b100001;
    localparam logic [5:0] SB  = 6'b100011;

    task automatic fd(input logic [5:0] o, input logic [5:0] f,
                      input logic z);
        tbl.push_back(V(o,f,z,1,1,1,4'b1100,0,0,0,0,0,0,0));
        tbl.push_back(V(o,f,z,1,1,2,4'b0000,0,0,0,0,0,0,0));
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
        // reset: first cycle state unknown, then IDLE, then exit
        tbl.push_back(V(R,0,0,0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(V(R,0,0,0,1,0,0,0,0,0,0,0,0,0));
        tbl.push_back(V(R,0,0,1,1,0,0,0,0,0,0,0,0,0));
        // addu
        fd(R, AD, 0);
        tbl.push_back(V(R,AD,0,1,1,3,4'b0000,0,0,0,0,3'b000,0,0));
        tbl.push_back(V(R,AD,0,1,1,8,4'b0010,1,0,0,0,3'b000,0,0));
        // subu
        fd(R, SB, 0);
        tbl.push_back(V(R,SB,0,1,1,3,4'b0000,0,0,0,0,3'b001,0,0));
        tbl.push_back(V(R,SB,0,1,1,8,4'b0010,1,0,0,0,3'b001,0,0));
        // ori
        fd(ORI, 0, 0);
        tbl.push_back(V(ORI,0,0,1,1,3,4'b0000,0,0,1,0,3'b010,0,0));
        tbl.push_back(V(ORI,0,0,1,1,8,4'b0010,0,0,1,0,3'b010,0,0));
        // lui
        fd(LUI, 0, 0);
        tbl.push_back(V(LUI,0,0,1,1,3,4'b0000,0,0,1,2,3'b011,0,0));
        tbl.push_back(V(LUI,0,0,1,1,8,4'b0010,0,0,1,2,3'b011,0,0));
        // lw
        fd(LW, 0, 0);
        tbl.push_back(V(LW,0,0,1,1,4,4'b0000,0,0,1,1,3'b000,0,0));
        tbl.push_back(V(LW,0,0,1,1,5,4'b0000,0,0,0,0,0,0,0));
        tbl.push_back(V(LW,0,0,1,1,6,4'b0010,0,1,0,0,0,0,0));
        // sw
        fd(SW, 0, 0);
        tbl.push_back(V(SW,0,0,1,1,4,4'b0000,0,0,1,1,3'b000,0,0));
        tbl.push_back(V(SW,0,0,1,1,7,4'b0001,0,0,0,0,0,0,0));
        // beq taken / not taken
        fd(BEQ, 0, 1);
        tbl.push_back(V(BEQ,0,1,1,1,9,4'b1000,0,0,0,0,3'b001,1,0));
        fd(BEQ, 0, 0);
        tbl.push_back(V(BEQ,0,0,1,1,9,4'b0000,0,0,0,0,3'b001,1,0));
        // j / jal
        fd(J, 0, 0);
        tbl.push_back(V(J,0,0,1,1,10,4'b1000,0,0,0,0,0,2,0));
        fd(JAL, 0, 0);
        tbl.push_back(V(JAL,0,0,1,1,10,4'b1010,2,2,0,0,0,2,0));
        // illegal op, then illegal R funct
        tbl.push_back(V(BAD,0,0,1,1,1,4'b1100,0,0,0,0,0,0,0));
        tbl.push_back(V(BAD,0,0,1,1,2,4'b0000,0,0,0,0,0,0,1));
        tbl.push_back(V(R,0,0,1,1,1,4'b1100,0,0,0,0,0,0,0));
        tbl.push_back(V(R,0,0,1,1,2,4'b0000,0,0,0,0,0,0,1));
        // lw with reset during MEMRD
        fd(LW, 0, 0);
        tbl.push_back(V(LW,0,0,1,1,4,4'b0000,0,0,1,1,3'b000,0,0));
        tbl.push_back(V(LW,0,0,0,1,5,4'b0000,0,0,0,0,0,0,0));
        tbl.push_back(V(LW,0,0,1,1,0,4'b0000,0,0,0,0,0,0,0));
        tbl.push_back(V(LW,0,0,1,1,1,4'b1100,0,0,0,0,0,0,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // trap variant: reset both, fetch, decode illegal op
        op = BAD; funct = '0; zero = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("trap_idle", {28'd0, t_state}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_fetch", {28'd0, t_state}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_dec_ill", {31'd0, t_ill}, 32'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("trap_hold%0d", k),
                {28'd0, t_state}, 32'd11);
            chk($sformatf("trap_noen%0d", k),
                {28'd0, t_PCWr, t_IRWr, t_GPRWr, t_DMWr}, 32'd0);
            chk($sformatf("trap_u0_st%0d", k),
                {28'd0, state}, (k == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
